// File: rtl/mem_bank_responder.sv
// mem_bank_responder
// Four-bank, 64 x 16-bit word memory responder.
//
// A request is accepted only when it is legal and its target bank is idle.
// An accepted request loads the bank's busy counter, so the bank then reports
// busy for BUSY_CYCLES cycles.
// Reads return through a two-stage pipeline:
//   - stage 1 registers the bank and word index at acceptance;
//   - stage 2 performs the registered array read;
// so rd_valid arrives exactly two cycles after the accepting cycle.
// Memory contents are never reset. The counters and the pipeline are reset.
// BUSY_CYCLES is meaningful over 2..15 because the busy counters are 4 bits wide.

module mem_bank_responder #(
   parameter int unsigned BUSY_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] addr,
   input  logic [15:0] data_in,
   input  logic        wr,
   input  logic        rd,
   output logic [15:0] data_out,
   output logic        rd_valid,
   output logic        stall,
   output logic [3:0]  busy,
   output logic        err
);

   localparam int unsigned NUM_BANKS = 4;
   localparam int unsigned WORDS     = 64;
   localparam logic [3:0]  BUSY_LOAD = 4'(BUSY_CYCLES);

   // Request decode
   logic       req;
   logic       illegal;
   logic       target_busy;
   logic       accept;
   logic       accept_wr;
   logic       accept_rd;
   logic [1:0] req_bank;
   logic [5:0] req_index;

   // The upper address bits do not select anything.
   logic       unused_addr_hi;

   // Per-bank busy flags, collected from the generate loop
   logic [3:0] busy_vec;

   // Read pipeline
   logic        s1_valid_reg;
   logic [1:0]  s1_bank_reg;
   logic [5:0]  s1_index_reg;
   logic        rd_valid_reg;
   logic [1:0]  s2_bank_reg;

   // Registered read data from each bank
   logic [15:0] bank_rdata [NUM_BANKS];

   assign req_bank       = addr[2:1];
   assign req_index      = addr[8:3];
   assign unused_addr_hi = ^addr[15:9];

   // Classify the current request as idle, illegal, stalled or accepted.
   always_comb begin
      req         = rd | wr;
      illegal     = (rd & wr) | (req & addr[0]);
      target_busy = busy_vec[req_bank];
      accept      = req & ~illegal & ~target_busy;
      accept_wr   = accept & wr;
      accept_rd   = accept & rd;
      err         = illegal;
      stall       = req & ~illegal & target_busy;
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
         logic [3:0]  count_reg;
         logic [3:0]  count_next;
         logic        bank_busy_reg;
         logic        bank_hit;
         logic [15:0] mem [0:WORDS-1];
         logic [15:0] rdata_reg;

         assign bank_hit = (req_bank == 2'(gi));

         // The counter reloads only on acceptance. The busy gate already
         // prevents acceptance while the counter is non-zero.
         always_comb begin
            count_next = count_reg;
            if (accept && bank_hit) begin
               count_next = BUSY_LOAD;
            end else if (count_reg != 4'd0) begin
               count_next = count_reg - 4'd1;
            end
         end

         // Busy counter and its registered busy flag.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               count_reg     <= 4'd0;
               bank_busy_reg <= 1'b0;
            end else begin
               count_reg     <= count_next;
               bank_busy_reg <= (count_next != 4'd0);
            end
         end

         // Bank storage: write on the accepting edge, registered read in stage 2.
         always_ff @(posedge clk) begin
            if (accept_wr && bank_hit) begin
               mem[req_index] <= data_in;
            end
            if (s1_valid_reg) begin
               rdata_reg <= mem[s1_index_reg];
            end
         end

         assign busy_vec[gi]   = bank_busy_reg;
         assign bank_rdata[gi] = rdata_reg;
      end
   endgenerate

   assign busy = busy_vec;

   // Read pipeline: the stage-1 address is captured at acceptance,
   // and the stage-2 valid/bank align with the array read.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid_reg <= 1'b0;
         s1_bank_reg  <= 2'd0;
         s1_index_reg <= 6'd0;
         rd_valid_reg <= 1'b0;
         s2_bank_reg  <= 2'd0;
      end else begin
         s1_valid_reg <= accept_rd;
         s1_bank_reg  <= req_bank;
         s1_index_reg <= req_index;
         rd_valid_reg <= s1_valid_reg;
         s2_bank_reg  <= s1_bank_reg;
      end
   end

   // Return data is forced to zero whenever no read is being returned.
   always_comb begin
      data_out = 16'h0000;
      if (rd_valid_reg) begin
         data_out = bank_rdata[s2_bank_reg];
      end
   end

   assign rd_valid = rd_valid_reg;

endmodule

// File: tb/tb_mem_bank_responder.sv
// Directed testbench for mem_bank_responder.
// Inputs change 1 ns after each rising edge. Outputs are checked 1 ns later.
// A second instance runs with BUSY_CYCLES=2.

module tb_mem_bank_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] addr, data_in, data_out;
   logic        wr, rd, rd_valid, stall, err;
   logic [3:0]  busy;

   logic [15:0] addr2, data_in2, data_out2;
   logic        wr2, rd2, rd_valid2, stall2, err2;
   logic [3:0]  busy2;

   int n_checks = 0;
   int n_fail   = 0;

   mem_bank_responder #(.BUSY_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .wr(wr), .rd(rd),
      .data_out(data_out), .rd_valid(rd_valid), .stall(stall), .busy(busy), .err(err)
   );

   mem_bank_responder #(.BUSY_CYCLES(2)) dut2 (
      .clk(clk), .rst(rst), .addr(addr2), .data_in(data_in2), .wr(wr2), .rd(rd2),
      .data_out(data_out2), .rd_valid(rd_valid2), .stall(stall2), .busy(busy2), .err(err2)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      rd = 1'b0; wr = 1'b0;
      repeat (n) cyc();
   endtask

   task automatic test_reset();
      rst = 1'b0; rd = 1'b0; wr = 1'b0; addr = 16'h0; data_in = 16'h0;
      rd2 = 1'b0; wr2 = 1'b0; addr2 = 16'h0; data_in2 = 16'h0;
      repeat (3) cyc();
      #1;
      n_checks++; if (busy !== 4'h0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0000", busy); end
      n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
      n_checks++; if (data_out !== 16'h0000) begin n_fail++; $display("FAIL reset_data_out: got %h expected 0000", data_out); end
      n_checks++; if (stall !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_stall_err: got %b%b expected 00", stall, err); end
      n_checks++; if (busy2 !== 4'h0) begin n_fail++; $display("FAIL reset_busy2: got %b expected 0000", busy2); end
      rst = 1'b1;
      cyc();
      $display("test_reset done");
   endtask

   task automatic test_write_read();
      idle(6);
      wr = 1'b1; rd = 1'b0; addr = 16'h0010; data_in = 16'hBEEF; #1;
      n_checks++; if (stall !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL wr_accept: stall/err got %b%b expected 00", stall, err); end
      cyc();
      wr = 1'b0; rd = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         #1;
         n_checks++; if (busy !== 4'b0001) begin n_fail++; $display("FAIL wr_busy c%0d: got %b expected 0001", c, busy); end
         n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rd_stall c%0d: got %b expected 1", c, stall); end
         cyc();
      end
      #1;
      n_checks++; if (busy !== 4'b0000 || stall !== 1'b0) begin n_fail++; $display("FAIL rd_accept c5: busy=%b stall=%b expected 0000/0", busy, stall); end
      cyc();
      rd = 1'b0; #1;
      n_checks++; if (rd_valid !== 1'b0 || busy !== 4'b0001) begin n_fail++; $display("FAIL rd_lat1: rd_valid=%b busy=%b expected 0/0001", rd_valid, busy); end
      cyc(); #1;
      n_checks++; if (rd_valid !== 1'b1 || data_out !== 16'hBEEF) begin n_fail++; $display("FAIL rd_data: rd_valid=%b data=%h expected 1/BEEF", rd_valid, data_out); end
      cyc(); #1;
      n_checks++; if (rd_valid !== 1'b0 || data_out !== 16'h0000) begin n_fail++; $display("FAIL rd_pulse_end: rd_valid=%b data=%h expected 0/0000", rd_valid, data_out); end
      $display("test_write_read done");
   endtask

   task automatic test_back_to_back();
      logic [3:0] eb;
      idle(6);
      for (int b = 0; b < 4; b++) begin
         wr = 1'b1; addr = 16'(b * 2); data_in = 16'hA000 + 16'(b); #1;
         n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_wr%0d: stall got %b expected 0", b, stall); end
         cyc();
      end
      idle(5);
      for (int c = 0; c <= 6; c++) begin
         if (c < 4) begin rd = 1'b1; addr = 16'(c * 2); end
         else rd = 1'b0;
         #1;
         eb = 4'((1 << c) - 1);
         if (c < 4) begin
            n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_stall c%0d: got %b expected 0", c, stall); end
         end
         if (c <= 4) begin
            n_checks++; if (busy !== eb) begin n_fail++; $display("FAIL b2b_busy c%0d: got %b expected %b", c, busy, eb); end
         end
         n_checks++; if (rd_valid !== (c >= 2 && c <= 5)) begin n_fail++; $display("FAIL b2b_valid c%0d: got %b", c, rd_valid); end
         if (c >= 2 && c <= 5) begin
            n_checks++; if (data_out !== 16'hA000 + 16'(c - 2)) begin n_fail++; $display("FAIL b2b_data c%0d: got %h expected %h", c, data_out, 16'hA000 + 16'(c - 2)); end
         end
         cyc();
      end
      $display("test_back_to_back done");
   endtask

   task automatic test_illegal();
      idle(6);
      rd = 1'b1; wr = 1'b1; addr = 16'h0010; data_in = 16'h1234; #1;
      n_checks++; if (err !== 1'b1 || stall !== 1'b0) begin n_fail++; $display("FAIL ill_rdwr: err/stall got %b%b expected 10", err, stall); end
      cyc();
      rd = 1'b0; wr = 1'b0; #1;
      n_checks++; if (busy !== 4'b0000 || err !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL ill_nostate: busy=%b err=%b stall=%b expected 0000/0/0", busy, err, stall); end
      cyc();
      rd = 1'b1; addr = 16'h0003; #1;
      n_checks++; if (err !== 1'b1 || stall !== 1'b0) begin n_fail++; $display("FAIL ill_misalign: err/stall got %b%b expected 10", err, stall); end
      cyc();
      rd = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_checks++; if (rd_valid !== 1'b0 || busy !== 4'b0000) begin n_fail++; $display("FAIL ill_noret c%0d: rd_valid=%b busy=%b expected 0/0000", c, rd_valid, busy); end
         cyc();
      end
      rd = 1'b1; addr = 16'h0010; #1;
      n_checks++; if (stall !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL ill_readback_acc: stall/err got %b%b expected 00", stall, err); end
      cyc();
      rd = 1'b0; wr = 1'b1; addr = 16'h0011; data_in = 16'h7777; #1;
      n_checks++; if (err !== 1'b1 || stall !== 1'b0) begin n_fail++; $display("FAIL ill_busybank: err/stall got %b%b expected 10", err, stall); end
      cyc();
      wr = 1'b0; #1;
      n_checks++; if (rd_valid !== 1'b1 || data_out !== 16'hBEEF) begin n_fail++; $display("FAIL ill_nowrite: rd_valid=%b data=%h expected 1/BEEF", rd_valid, data_out); end
      cyc();
      $display("test_illegal done");
   endtask

   task automatic test_stall_hold();
      idle(6);
      wr = 1'b1; addr = 16'h000A; data_in = 16'h1111; #1;
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL hold_first: stall got %b expected 0", stall); end
      cyc();
      data_in = 16'h2222;
      for (int c = 1; c <= 4; c++) begin
         #1;
         n_checks++; if (stall !== 1'b1 || busy !== 4'b0010) begin n_fail++; $display("FAIL hold_stall c%0d: stall=%b busy=%b expected 1/0010", c, stall, busy); end
         cyc();
      end
      #1;
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL hold_accept c5: stall got %b expected 0", stall); end
      cyc();
      wr = 1'b0; #1;
      n_checks++; if (busy !== 4'b0010) begin n_fail++; $display("FAIL hold_reload: busy got %b expected 0010", busy); end
      idle(5);
      rd = 1'b1; addr = 16'h000A; #1;
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL hold_rd_acc: stall got %b expected 0", stall); end
      cyc();
      rd = 1'b0;
      cyc(); #1;
      n_checks++; if (rd_valid !== 1'b1 || data_out !== 16'h2222) begin n_fail++; $display("FAIL hold_data: rd_valid=%b data=%h expected 1/2222", rd_valid, data_out); end
      cyc();
      $display("test_stall_hold done");
   endtask

   task automatic test_reset_mid_read();
      idle(6);
      rd = 1'b1; addr = 16'h0010; #1;
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rstmid_acc: stall got %b expected 0", stall); end
      cyc();
      rd = 1'b0; #1;
      n_checks++; if (busy !== 4'b0001) begin n_fail++; $display("FAIL rstmid_pre: busy got %b expected 0001", busy); end
      rst = 1'b0; #1;
      n_checks++; if (busy !== 4'b0000 || rd_valid !== 1'b0 || data_out !== 16'h0000) begin n_fail++; $display("FAIL rstmid_clear: busy=%b rd_valid=%b data=%h expected 0000/0/0000", busy, rd_valid, data_out); end
      cyc(); #1;
      n_checks++; if (rd_valid !== 1'b0 || data_out !== 16'h0000) begin n_fail++; $display("FAIL rstmid_slot: rd_valid=%b data=%h expected 0/0000", rd_valid, data_out); end
      cyc();
      rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         cyc(); #1;
         n_checks++; if (rd_valid !== 1'b0 || busy !== 4'b0000) begin n_fail++; $display("FAIL rstmid_after c%0d: rd_valid=%b busy=%b expected 0/0000", c, rd_valid, busy); end
      end
      cyc();
      rd = 1'b1; addr = 16'h0010; #1;
      n_checks++; if (stall !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL rstmid_first: stall/err got %b%b expected 00", stall, err); end
      cyc();
      rd = 1'b0;
      cyc(); #1;
      n_checks++; if (rd_valid !== 1'b1 || data_out !== 16'hBEEF) begin n_fail++; $display("FAIL rstmid_data: rd_valid=%b data=%h expected 1/BEEF", rd_valid, data_out); end
      cyc();
      $display("test_reset_mid_read done");
   endtask

   task automatic test_busy_param();
      wr2 = 1'b1; addr2 = 16'h0004; data_in2 = 16'h5A5A; #1;
      n_checks++; if (stall2 !== 1'b0) begin n_fail++; $display("FAIL p2_first: stall got %b expected 0", stall2); end
      cyc();
      data_in2 = 16'hA5A5; #1;
      n_checks++; if (stall2 !== 1'b1 || busy2 !== 4'b0100) begin n_fail++; $display("FAIL p2_c1: stall=%b busy=%b expected 1/0100", stall2, busy2); end
      cyc(); #1;
      n_checks++; if (stall2 !== 1'b1) begin n_fail++; $display("FAIL p2_c2: stall got %b expected 1", stall2); end
      cyc(); #1;
      n_checks++; if (stall2 !== 1'b0) begin n_fail++; $display("FAIL p2_c3: stall got %b expected 0", stall2); end
      cyc();
      wr2 = 1'b0; #1;
      n_checks++; if (busy2 !== 4'b0100) begin n_fail++; $display("FAIL p2_reload: busy got %b expected 0100", busy2); end
      cyc();
      cyc(); #1;
      n_checks++; if (busy2 !== 4'b0000) begin n_fail++; $display("FAIL p2_idle: busy got %b expected 0000", busy2); end
      rd2 = 1'b1; addr2 = 16'h0004; #1;
      n_checks++; if (stall2 !== 1'b0) begin n_fail++; $display("FAIL p2_rd_acc: stall got %b expected 0", stall2); end
      cyc();
      rd2 = 1'b0;
      cyc(); #1;
      n_checks++; if (rd_valid2 !== 1'b1 || data_out2 !== 16'hA5A5) begin n_fail++; $display("FAIL p2_data: rd_valid=%b data=%h expected 1/A5A5", rd_valid2, data_out2); end
      cyc();
      $display("test_busy_param done");
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_back_to_back();
      test_illegal();
      test_stall_hold();
      test_reset_mid_read();
      test_busy_param();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_bank_responder.md
MEM_BANK_RESPONDER -- requirements
Module: mem_bank_responder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst; all state SHALL clear while rst=0.
REQ-002 Parameter BUSY_CYCLES, default 4, SHALL set the number of cycles a bank reports busy after accepting a request; legal range is 2..15.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 addr  input  16  byte address; addr[0] is the alignment bit; bank = addr[2:1]; word index = addr[8:3]; addr[15:9] is ignored.
REQ-006 data_in  input  16  write data.
REQ-007 wr  input  1  write request, level-held by the requester until accepted.
REQ-008 rd  input  1  read request, level-held by the requester until accepted.
REQ-009 data_out  output  16  read data; valid only while rd_valid=1, otherwise 16'h0000.
REQ-010 rd_valid  output  1  single-cycle read-return pulse.
REQ-011 stall  output  1  combinational; the current request is not accepted this cycle.
REQ-012 busy  output  4  per-bank busy flags, registered.
REQ-013 err  output  1  combinational; the current request is illegal and is dropped.

Function
REQ-014 Storage SHALL be 4 banks x 64 words x 16 bits; contents SHALL NOT be reset.
REQ-015 A request SHALL exist when rd|wr=1.
REQ-016 An illegal request SHALL raise err=1 that cycle, keep stall=0, and cause no state change.
- rd&wr both 1 is illegal.
- addr[0]=1 is illegal.
REQ-017 A legal request SHALL be stalled (stall=1, no state change) while busy[bank]=1.
REQ-018 A legal request SHALL be accepted when busy[bank]=0; stall=0 and err=0 that cycle.
REQ-019 An accepted write SHALL store data_in at [bank][index] on the accepting clock edge.
REQ-020 On acceptance, the bank counter SHALL load BUSY_CYCLES, decrement each cycle to 0, and drive busy[b] = (count != 0).
- busy[b] therefore rises the cycle after acceptance and stays high for exactly BUSY_CYCLES cycles.
REQ-021 An accepted read SHALL return the stored word with rd_valid=1 exactly 2 cycles after the accepting cycle, through a 2-stage pipeline of valid+bank+index.
- The array is read in stage 2.
REQ-022 The block SHALL accept at most one request per cycle.
- Back-to-back requests to different idle banks SHALL each be accepted on consecutive cycles.
- Their read returns SHALL appear on consecutive cycles, in issue order.
REQ-023 A read SHALL return the data of any write accepted to the same word before the read's acceptance.
REQ-024 Requests with rd=wr=0 SHALL have no effect; stall=0 and err=0.
REQ-025 The counter SHALL be reloaded only on acceptance; the busy gate makes reload while busy impossible.

Reset
REQ-026 While rst=0, the block SHALL hold all counters at 0, busy=4'h0, pipeline valids at 0, rd_valid=0, and data_out=16'h0000.
REQ-027 Asserting rst mid-operation SHALL discard in-flight reads, so no rd_valid occurs for them, and SHALL clear busy immediately.
REQ-028 The first request after rst rises SHALL be accepted when otherwise legal.

Verification
REQ-029 Write then read, same bank:
- Stimulus: wr addr=16'h0010 data=16'hBEEF; then rd addr=16'h0010 held.
- Response: busy[0]=1 for 4 cycles; the read stalls until busy[0]=0; data_out=16'hBEEF with rd_valid exactly 2 cycles after acceptance.
REQ-030 Bank interleave:
- Stimulus: reads to 16'h0000, 16'h0002, 16'h0004, 16'h0006 on 4 consecutive cycles.
- Response: no stall; busy goes 0001, 0011, 0111, 1111; four rd_valid pulses on consecutive cycles in order.
REQ-031 Illegal requests:
- rd=wr=1 gives err=1 and stall=0, busy unchanged, no write.
- rd with addr=16'h0003 gives err=1 and no rd_valid.
REQ-032 Stall hold:
- Stimulus: wr to bank 1, then a held wr to bank 1 with different data.
- Response: stall=1 for 4 cycles, accepted on cycle 5; a readback returns the second data.
REQ-033 Reset mid-read:
- Stimulus: accept rd, assert rst=0 one cycle later.
- Response: busy=4'h0, rd_valid never asserts, data_out=16'h0000.
REQ-034 Parameter sweep:
- Stimulus: BUSY_CYCLES=2.
- Response: same-bank re-accept is possible 3 cycles after the first acceptance.
